// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// default program capacity and word size.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      CHECK = 3'd3,
      RUN   = 3'd4,
      ERROR = 3'd5
   } state_t;

   localparam int MAX_WORDS_DEF = 64;
   localparam int WORD_BYTES    = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8-to-32 MSB-first byte packer: shifts bytes in on load and flags when the
// next accepted byte completes the word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstd,
   input  logic        clr,
   input  logic        load,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0] cnt;

   // full means three bytes are held, so the byte now on din is the last one
   assign full = (cnt == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         cnt  <= '0;
         word <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         word <= {word[23:0], din};
         cnt  <= cnt + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: header byte N, then 4N bytes packed big-endian into
// words written at 0,4,8,...; holds the CPU in reset until done.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rstd,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rstd,
   output logic              done,
   output logic              err
);

   localparam int WC_W = $clog2(MAX_WORDS + 1);

   state_t            state, state_nx;
   logic [WC_W-1:0]   word_cnt;
   logic [WC_W-1:0]   n_words;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W-1:0] cur_addr;
   logic              rdy;
   logic              bad_hdr;
   logic              last_word;
   logic              pk_clr, pk_load, pk_full;
   logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   byte_packer u_packer (
      .clk  (clk),
      .rstd (rstd),
      .clr  (pk_clr),
      .load (pk_load),
      .din  (in_data),
      .word (pk_word),
      .full (pk_full)
   );

   assign cur_addr  = ADDR_W'({word_cnt, 2'b00});
   assign bad_hdr   = (in_data == 8'd0) || (int'(in_data) > MAX_WORDS);
   assign last_word = ((word_cnt + WC_W'(1)) == n_words);

   always_comb begin
      state_nx = state;
      rdy      = 1'b0;
      pk_clr   = 1'b0;
      pk_load  = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (in_valid) begin
               if (bad_hdr) begin
                  state_nx = ERROR;
               end else begin
                  pk_clr   = 1'b1;
                  state_nx = LOAD;
               end
            end
         end
         LOAD: begin
            rdy = 1'b1;
            if (in_valid) begin
               pk_load = 1'b1;
               if (pk_full) state_nx = WRITE;
            end
         end
         WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nx = last_word ? CHECK : LOAD;
`else
            state_nx = last_word ? RUN : LOAD;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            rdy = 1'b1;
            if (in_valid) state_nx = (in_data == csum) ? RUN : ERROR;
         end
`endif
         RUN, ERROR: begin
            if (reload) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address/data are driven live during WRITE and held from the hold registers otherwise
   assign in_ready   = rstd & rdy;
   assign imem_we    = (state == WRITE);
   assign imem_waddr = imem_we ? cur_addr : waddr_q;
   assign imem_wdata = imem_we ? pk_word : wdata_q;
   assign cpu_rstd   = (state == RUN);
   assign done       = (state == RUN);
   assign err        = (state == ERROR);

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state    <= IDLE;
         word_cnt <= '0;
         n_words  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            word_cnt <= '0;
            n_words  <= WC_W'(in_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (pk_load) csum <= csum ^ in_data;
`endif
         if (state == WRITE) begin
            word_cnt <= word_cnt + WC_W'(1);
            waddr_q  <= cur_addr;
            wdata_q  <= pk_word;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-cycle vector table plus directed
// multi-cycle sequences (stall, async reset, max length, checksum).
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rstd;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reload;
   logic        imem_we;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rstd;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   imem_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
      .clk        (clk),
      .rstd       (rstd),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rstd   (cpu_rstd),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // write monitor: shadow memory and pulse count
   logic [31:0] mem [0:63];
   int          we_cnt = 0;
   logic [7:0]  last_addr = 8'h00;
   always @(negedge clk) begin
      if (rstd && imem_we) begin
         we_cnt++;
         last_addr = imem_waddr;
         mem[imem_waddr[7:2]] = imem_wdata;
      end
   end

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        rl;
      logic        rdy;
      logic        we;
      logic [7:0]  a;
      logic [31:0] wd;
      logic        dn;
      logic        er;
      logic        cpu;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic addv(input logic v, input logic [7:0] d, input logic rl, input logic rdy,
                       input logic we, input logic [7:0] a, input logic [31:0] wd,
                       input logic dn, input logic er, input logic cpu);
      vec_t e;
      e.v = v; e.d = d; e.rl = rl; e.rdy = rdy; e.we = we; e.a = a; e.wd = wd;
      e.dn = dn; e.er = er; e.cpu = cpu;
      tbl.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstd = 1'b0; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
      @(negedge clk);
      rstd = 1'b1;
   endtask

   // called and returns just after a falling edge
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      #1;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_byte_timeout actual=%h required=ready", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_check(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(b);
`endif
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!(done || err) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("wait_done_timeout", 32'(t < 50), 32'd1);
   endtask

   initial begin
      int base;
      int bad;
      rstd = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_waddr), 32'd0);
      chk("rst_data", imem_wdata, 32'd0);
      chk("rst_cpu", 32'(cpu_rstd), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rstd = 1'b1;

      // normal two-word load, in_valid held high
      addv(1, 8'h02, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
      addv(1, 8'h8C, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
      addv(1, 8'h01, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
      addv(1, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
      addv(1, 8'h00, 0, 1, 0, 8'h00, 32'h0, 0, 0, 0);
      addv(1, 8'h00, 0, 0, 1, 8'h00, 32'h8C010000, 0, 0, 0);
      addv(1, 8'h00, 0, 1, 0, 8'h00, 32'h8C010000, 0, 0, 0);
      addv(1, 8'h22, 0, 1, 0, 8'h00, 32'h8C010000, 0, 0, 0);
      addv(1, 8'h18, 0, 1, 0, 8'h00, 32'h8C010000, 0, 0, 0);
      addv(1, 8'h20, 0, 1, 0, 8'h00, 32'h8C010000, 0, 0, 0);
      addv(1, 8'h97, 0, 0, 1, 8'h04, 32'h00221820, 0, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      addv(1, 8'h97, 0, 1, 0, 8'h04, 32'h00221820, 0, 0, 0);
`endif
      addv(0, 8'h00, 0, 0, 0, 8'h04, 32'h00221820, 1, 0, 1);
      addv(0, 8'h00, 1, 0, 0, 8'h04, 32'h00221820, 1, 0, 1);
      addv(0, 8'h00, 0, 1, 0, 8'h04, 32'h00221820, 0, 0, 0);
      // bad headers 00 and 41, each cleared by reload
      addv(1, 8'h00, 0, 1, 0, 8'h04, 32'h00221820, 0, 0, 0);
      addv(0, 8'h00, 0, 0, 0, 8'h04, 32'h00221820, 0, 1, 0);
      addv(1, 8'h55, 1, 0, 0, 8'h04, 32'h00221820, 0, 1, 0);
      addv(1, 8'h41, 0, 1, 0, 8'h04, 32'h00221820, 0, 0, 0);
      addv(1, 8'h01, 0, 0, 0, 8'h04, 32'h00221820, 0, 1, 0);
      addv(0, 8'h00, 0, 0, 0, 8'h04, 32'h00221820, 0, 1, 0);
      addv(0, 8'h00, 1, 0, 0, 8'h04, 32'h00221820, 0, 1, 0);
      addv(0, 8'h00, 0, 1, 0, 8'h04, 32'h00221820, 0, 0, 0);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         reload   = tbl[i].rl;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_we", i), 32'(imem_we), 32'(tbl[i].we));
         chk($sformatf("v%0d_addr", i), 32'(imem_waddr), 32'(tbl[i].a));
         chk($sformatf("v%0d_data", i), imem_wdata, tbl[i].wd);
         chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
         chk($sformatf("v%0d_cpu", i), 32'(cpu_rstd), 32'(tbl[i].cpu));
         @(negedge clk);
      end
      in_valid = 1'b0;
      reload   = 1'b0;

      // stall: in_valid pattern 1,0,0,1,...
      do_reset();
      base = we_cnt;
      send_byte(8'h01);
      send_byte(8'hAA); repeat (2) @(negedge clk);
      send_byte(8'hBB); repeat (2) @(negedge clk);
      send_byte(8'hCC); repeat (2) @(negedge clk);
      send_byte(8'hDD);
      send_check(8'h00);
      wait_done();
      chk("stall_we_count", 32'(we_cnt - base), 32'd1);
      chk("stall_data", mem[0], 32'hAABBCCDD);
      chk("stall_addr", 32'(last_addr), 32'h00);
      chk("stall_done", 32'(done), 32'd1);

      // asynchronous reset in the middle of word 2
      do_reset();
      send_byte(8'h03);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06);
      chk("mid_first_word", mem[0], 32'h01020304);
      #2 rstd = 1'b0;
      #1;
      chk("async_ready", 32'(in_ready), 32'd0);
      chk("async_we", 32'(imem_we), 32'd0);
      chk("async_addr", 32'(imem_waddr), 32'd0);
      chk("async_data", imem_wdata, 32'd0);
      chk("async_cpu_done_err", {29'd0, cpu_rstd, done, err}, 32'd0);
      @(negedge clk);
      rstd = 1'b1;
      #1;
      chk("after_rst_ready", 32'(in_ready), 32'd1);
      base = we_cnt;
      send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_check(8'h44);
      wait_done();
      chk("reload_data", mem[0], 32'h11223344);
      chk("reload_addr", 32'(last_addr), 32'h00);
      chk("reload_we_count", 32'(we_cnt - base), 32'd1);

      // maximum-length program
      do_reset();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      base = we_cnt;
      send_byte(8'h40);
      for (int i = 0; i < 64; i++) begin
         send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00); send_byte(8'(i));
      end
      send_check(8'h00);
      wait_done();
      chk("max_we_count", 32'(we_cnt - base), 32'd64);
      chk("max_last_addr", 32'(last_addr), 32'hFC);
      chk("max_done", 32'(done), 32'd1);
      chk("max_cpu", 32'(cpu_rstd), 32'd1);
      chk("max_ready", 32'(in_ready), 32'd0);
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== (32'hA0000000 | 32'(i))) bad++;
      chk("max_mem_bad_words", 32'(bad), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_reset();
      send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0F);
      wait_done();
      chk("csum_ok_done", 32'(done), 32'd1);
      chk("csum_ok_cpu", 32'(cpu_rstd), 32'd1);
      chk("csum_ok_err", 32'(err), 32'd0);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      send_byte(8'h01);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0E);
      wait_done();
      chk("csum_bad_err", 32'(err), 32'd1);
      chk("csum_bad_cpu", 32'(cpu_rstd), 32'd0);
      chk("csum_bad_done", 32'(done), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
